score_bin2bcd: RTL and testbench

//  Sequential binary-to-BCD converter (shift-and-add-3) for the score path.

---
 rtl/score_pkg.sv | 23 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/score_bin2bcd.sv | 108 ++++++++++
 tb/tb_score_bin2bcd.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared constants and helpers for the score BCD path
package score_pkg;

    localparam int          DIGIT_W       = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'h9;
    localparam logic [3:0]  ADJ_THRESH    = 4'd5;
    localparam logic [3:0]  ADJ_ADD       = 4'd3;

    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  SHIFT = 2'd1;
    localparam logic [1:0]  DONE  = 2'd2;

    // 10^n, used at elaboration time to size the overflow limit
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational "if >= 5 add 3" BCD digit correction cell
module bcd_digit_adj
    import score_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Pre-shift correction so that the following doubling carries into the next digit
    always_comb begin
        digit_o = (digit_i >= ADJ_THRESH) ? (digit_i + ADJ_ADD) : digit_i;
    end

endmodule

// File: rtl/score_bin2bcd.sv
// rtl/score_bin2bcd.sv - sequential shift-and-add-3 binary to packed BCD converter
module score_bin2bcd
    import score_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                    overflow
);

    localparam int BCD_W  = DIGIT_W * DIGITS;
    localparam int SR_W   = BIN_W + BCD_W;
    localparam int ITER_W = $clog2(BIN_W + 1);

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);
    localparam int unsigned       LIMIT_INT = pow10(DIGITS) - 1;
    localparam logic [BIN_W:0]    BCD_LIMIT = LIMIT_INT[BIN_W:0];

    logic [1:0]        state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [SR_W-1:0]   sr_adj;
    logic              ovf_q, ovf_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;

    // Digit corrections apply only to the BCD field; the binary tail passes through
    assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (sr_q  [BIN_W + DIGIT_W*g +: DIGIT_W]),
            .digit_o (sr_adj[BIN_W + DIGIT_W*g +: DIGIT_W])
        );
    end

    // Next-state logic: accept in IDLE, BIN_W shift iterations, publish in DONE
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        sr_d       = sr_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sr_d    = {{BCD_W{1'b0}}, bin_in};
                    iter_d  = '0;
                    ovf_d   = ({1'b0, bin_in} > BCD_LIMIT);
                end
            end
            SHIFT: begin
                sr_d   = sr_adj << 1;
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d      = ovf_q ? {DIGITS{BCD_MAX_DIGIT}} : sr_q[SR_W-1 -: BCD_W];
                overflow_d = ovf_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            iter_q     <= '0;
            sr_q       <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            sr_q       <= sr_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_score_bin2bcd.sv
// tb/tb_score_bin2bcd.sv - directed vector bench for score_bin2bcd
module tb_score_bin2bcd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs [12];

    score_bin2bcd #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full conversion: returns the number of edges from accept to the done sample
    task automatic convert(input logic [13:0] b, output int lat);
        lat = 0;
        @(negedge clk);
        bin_in = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int dcyc;
        int dlist [3];
        logic [15:0] prev_bcd;
        logic [15:0] exp_seq [3];

        vecs[0]  = '{14'd1234,  16'h1234, 1'b0};
        vecs[1]  = '{14'd0,     16'h0000, 1'b0};
        vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
        vecs[3]  = '{14'd10000, 16'h9999, 1'b1};
        vecs[4]  = '{14'd16383, 16'h9999, 1'b1};
        vecs[5]  = '{14'd42,    16'h0042, 1'b0};
        vecs[6]  = '{14'd1,     16'h0001, 1'b0};
        vecs[7]  = '{14'd5,     16'h0005, 1'b0};
        vecs[8]  = '{14'd99,    16'h0099, 1'b0};
        vecs[9]  = '{14'd100,   16'h0100, 1'b0};
        vecs[10] = '{14'd8191,  16'h8191, 1'b0};
        vecs[11] = '{14'd4095,  16'h4095, 1'b0};

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd", 32'(bcd_out), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].bin, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd15);
            chk($sformatf("v%0d_bcd", i), 32'(bcd_out), 32'(vecs[i].bcd));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_single", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_bcd_hold", i), 32'(bcd_out), 32'(vecs[i].bcd));
        end

        // start pulses during SHIFT and DONE must be ignored
        @(negedge clk);
        bin_in = 14'd567;
        start  = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        dcyc  = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start  = (c == 3 || c == 15);
            bin_in = 14'd999;
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                dcyc = c;
            end
        end
        start = 1'b0;
        chk("ign_done_count", 32'(ndone), 32'd1);
        chk("ign_done_cycle", 32'(dcyc), 32'd15);
        chk("ign_bcd", 32'(bcd_out), 32'h0567);
        chk("ign_busy_end", 32'(busy), 32'd0);

        // reset in the middle of a conversion
        convert(14'd42, lat);
        chk("pre_rst_bcd", 32'(bcd_out), 32'h0042);
        @(negedge clk);
        bin_in = 14'd8888;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_bcd", 32'(bcd_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        convert(14'd8888, lat);
        chk("restart_latency", 32'(lat), 32'd15);
        chk("restart_bcd", 32'(bcd_out), 32'h8888);

        // start held high: back-to-back conversions every 16 cycles
        exp_seq[0] = 16'h0001;
        exp_seq[1] = 16'h0002;
        exp_seq[2] = 16'h0003;
        @(negedge clk);
        bin_in = 14'd1;
        start  = 1'b1;
        ndone  = 0;
        prev_bcd = bcd_out;
        for (int c = 0; c < 80 && ndone < 3; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dlist[ndone] = c;
                chk($sformatf("held_bcd%0d", ndone), 32'(bcd_out), 32'(exp_seq[ndone]));
                ndone++;
                prev_bcd = bcd_out;
                @(negedge clk);
                bin_in = 14'(ndone + 1);
                if (ndone == 3) start = 1'b0;
            end else if (bcd_out !== prev_bcd) begin
                chk($sformatf("held_stable_c%0d", c), 32'(bcd_out), 32'(prev_bcd));
                prev_bcd = bcd_out;
            end
        end
        start = 1'b0;
        chk("held_done_count", 32'(ndone), 32'd3);
        if (ndone == 3) begin
            chk("held_first", 32'(dlist[0]), 32'd15);
            chk("held_space1", 32'(dlist[1] - dlist[0]), 32'd16);
            chk("held_space2", 32'(dlist[2] - dlist[1]), 32'd16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
